vera_bus_master: RTL and testbench

//  Bus initiator for the VERA external register bus (extbus_cs_n/rd_n/wr_n/a/d).

---
 rtl/vera_bus_master_pkg.sv | 32 +++
 rtl/vera_bus_master_if.sv | 31 +++
 rtl/vera_irq_sync.sv | 30 +++
 rtl/vera_bus_master.sv | 156 +++++++++++++++
 tb/tb_vera_bus_master.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/vera_bus_master_pkg.sv
// -----------------------------------------------------------------------------
// vera_bus_master_pkg
// Shared definitions for the VERA external-bus initiator:
//   - state_e    : transaction FSM states
//   - REG_*      : VERA register addresses as seen on extbus_a
//   - cyc_load() : converts a cycle count (1..15) into a down-counter load value
// -----------------------------------------------------------------------------
package vera_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } state_e;

  localparam logic [4:0] REG_ADDRX_L = 5'h00;
  localparam logic [4:0] REG_ADDRX_M = 5'h01;
  localparam logic [4:0] REG_ADDRX_H = 5'h02;
  localparam logic [4:0] REG_DATA0   = 5'h03;
  localparam logic [4:0] REG_DATA1   = 5'h04;
  localparam logic [4:0] REG_CTRL    = 5'h05;
  localparam logic [4:0] REG_IEN     = 5'h06;
  localparam logic [4:0] REG_ISR     = 5'h07;

  // A phase lasting N cycles loads N-1 and leaves the phase when the count hits 0.
  function automatic logic [3:0] cyc_load(input int unsigned cyc);
    return 4'(cyc - 1);
  endfunction

endpackage

// File: rtl/vera_bus_master_if.sv
// -----------------------------------------------------------------------------
// vera_bus_master_if
// Command/response channel between a command source and vera_bus_master.
//   cmd_valid/cmd_ready : handshake, one command outstanding at a time
//   cmd_write           : 1 = write, 0 = read
//   cmd_addr, cmd_wdata : VERA register address and write data
//   rsp_valid           : one-cycle completion pulse per accepted command
//   rsp_rdata           : last read data, held until the next read completes
// Modports: master = command source, slave = vera_bus_master.
// -----------------------------------------------------------------------------
interface vera_bus_master_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/vera_irq_sync.sv
// -----------------------------------------------------------------------------
// vera_irq_sync
// Two-flop synchroniser for VERA's asynchronous active-low interrupt.
// Inverts at the input so both flops carry the active-high sense and reset
// to "deasserted". No filtering; 2-cycle latency.
//   clk       in  system clock
//   reset     in  asynchronous, active-high reset
//   irq_n_in  in  asynchronous interrupt, active-low
//   irq       out synchronised interrupt, active-high
// -----------------------------------------------------------------------------
module vera_irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq_n_in,
  output logic irq
);

  logic irq_meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_meta <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq_meta <= ~irq_n_in;
      irq      <= irq_meta;
    end
  end

endmodule

// File: rtl/vera_bus_master.sv
// -----------------------------------------------------------------------------
// vera_bus_master
// Initiator for the VERA external register bus. Accepts one read/write command
// at a time and plays it out as SETUP -> STROBE -> HOLD -> RESP with
// programmable phase lengths, returning read data and a completion pulse.
// Every output is a flop. The pad top level builds
// extbus_d = extbus_d_oe ? extbus_d_out : 'z.
// Parameters (each 1..15): SETUP_CYC, STROBE_CYC, HOLD_CYC.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   bus (slave)                command/response channel
//   extbus_cs_n/rd_n/wr_n      chip select and strobes, active-low
//   extbus_a, extbus_d_out     address and write data to the pads
//   extbus_d_oe                1 = drive extbus_d
//   extbus_d_in                data from the pads
//   extbus_irq_n / irq         raw VERA interrupt / synchronised active-high irq
// -----------------------------------------------------------------------------
module vera_bus_master
  import vera_bus_master_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic               clk,
  input  logic               reset,
  vera_bus_master_if.slave   bus,
  output logic               extbus_cs_n,
  output logic               extbus_rd_n,
  output logic               extbus_wr_n,
  output logic [4:0]         extbus_a,
  output logic [7:0]         extbus_d_out,
  output logic               extbus_d_oe,
  input  logic [7:0]         extbus_d_in,
  input  logic               extbus_irq_n,
  output logic               irq
);

  localparam logic [3:0] SETUP_LD  = cyc_load(SETUP_CYC);
  localparam logic [3:0] STROBE_LD = cyc_load(STROBE_CYC);
  localparam logic [3:0] HOLD_LD   = cyc_load(HOLD_CYC);

  state_e     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       wr_q;
  logic       accept;
  logic       cur_write;
  logic       nx_active;
  logic       capture;

  assign accept    = bus.cmd_valid && bus.cmd_ready;
  // Direction of the transaction the next state belongs to: on the accept
  // edge the latched flag is not yet valid, so take it from the command.
  assign cur_write = accept ? bus.cmd_write : wr_q;
  assign nx_active = (state_next == ST_SETUP) || (state_next == ST_STROBE) ||
                     (state_next == ST_HOLD);
  // Read data is sampled on the edge that ends the last strobe cycle.
  assign capture   = (state == ST_STROBE) && (cnt == 4'd0) && !wr_q;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch can be inferred.
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SETUP;
          cnt_next   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt == 4'd0) begin
          state_next = ST_STROBE;
          cnt_next   = STROBE_LD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt == 4'd0) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt == 4'd0) begin
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ST_RESP: begin
        // Back-to-back command: RESP already has cs_n high, giving the gap.
        if (accept) begin
          state_next = ST_SETUP;
          cnt_next   = SETUP_LD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      wr_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking for all flops, so every flop sees pre-edge values
      // regardless of statement order.
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) wr_q <= bus.cmd_write;
    end
  end

  // Outputs are decoded from the next state so they line up with the state
  // register while still coming straight out of flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 8'h00;
      extbus_cs_n   <= 1'b1;
      extbus_rd_n   <= 1'b1;
      extbus_wr_n   <= 1'b1;
      extbus_a      <= 5'h00;
      extbus_d_out  <= 8'h00;
      extbus_d_oe   <= 1'b0;
    end else begin
      bus.cmd_ready <= (state_next == ST_IDLE) || (state_next == ST_RESP);
      bus.rsp_valid <= (state_next == ST_RESP);
      extbus_cs_n   <= !nx_active;
      extbus_rd_n   <= !((state_next == ST_STROBE) && !cur_write);
      extbus_wr_n   <= !((state_next == ST_STROBE) && cur_write);
      extbus_d_oe   <= nx_active && cur_write;
      if (accept) begin
        extbus_a <= bus.cmd_addr;
        if (bus.cmd_write) extbus_d_out <= bus.cmd_wdata;
      end
      if (capture) bus.rsp_rdata <= extbus_d_in;
    end
  end

  vera_irq_sync u_irq_sync (
    .clk      (clk),
    .reset    (reset),
    .irq_n_in (extbus_irq_n),
    .irq      (irq)
  );

endmodule

// File: tb/tb_vera_bus_master.sv
// -----------------------------------------------------------------------------
// tb_vera_bus_master
// Directed bench for vera_bus_master: a table of single commands checked
// cycle by cycle against the default timing, plus hand-written sequences for
// back-to-back commands, reset mid-strobe, non-default timing and irq sync.
// -----------------------------------------------------------------------------
module tb_vera_bus_master;
  import vera_bus_master_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vera_bus_master_if bus ();
  vera_bus_master_if bus2 ();

  logic       cs_n, rd_n, wr_n, d_oe, irq_n, irq;
  logic [4:0] a;
  logic [7:0] d_out, d_in;
  logic       cs2_n, rd2_n, wr2_n, d2_oe, irq2;
  logic [4:0] a2;
  logic [7:0] d2_out;
  logic [7:0] d2_in;

  // Pad model: VERA drives register contents only while rd_n is low.
  logic [7:0] pad_mem [32];
  assign d_in  = !rd_n ? pad_mem[a] : 8'h00;
  assign d2_in = 8'h00;

  vera_bus_master u_dut (
    .clk(clk), .reset(reset), .bus(bus),
    .extbus_cs_n(cs_n), .extbus_rd_n(rd_n), .extbus_wr_n(wr_n),
    .extbus_a(a), .extbus_d_out(d_out), .extbus_d_oe(d_oe),
    .extbus_d_in(d_in), .extbus_irq_n(irq_n), .irq(irq)
  );

  vera_bus_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2),
    .extbus_cs_n(cs2_n), .extbus_rd_n(rd2_n), .extbus_wr_n(wr2_n),
    .extbus_a(a2), .extbus_d_out(d2_out), .extbus_d_oe(d2_oe),
    .extbus_d_in(d2_in), .extbus_irq_n(irq_n), .irq(irq2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       write;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] pad;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  // Issues one command on DUT1 (call at a negedge) and checks cycles k=1..6
  // after the accept edge against the default 1/2/1 timing.
  task automatic run_cmd(input string tag, input vec_t v);
    int n;
    logic [5:0] exp_ctl;
    logic strobe;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    pad_mem[v.addr] = v.pad;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      check({tag, "_accept_timeout"}, 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      strobe  = (k == 2) || (k == 3);
      exp_ctl = {!(k <= 4), !(strobe && !v.write), !(strobe && v.write),
                 v.write && (k <= 4), k == 5, k >= 5};
      check($sformatf("%s_ctl_k%0d", tag, k),
            32'({cs_n, rd_n, wr_n, d_oe, bus.rsp_valid, bus.cmd_ready}), 32'(exp_ctl));
      if (k <= 4) check($sformatf("%s_addr_k%0d", tag, k), 32'(a), 32'(v.addr));
      if (v.write && k <= 4)
        check($sformatf("%s_dout_k%0d", tag, k), 32'(d_out), 32'(v.wdata));
      if (k == 5) check({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(v.exp_rdata));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_strobes"}, 32'({cs_n, rd_n, wr_n}), 32'(3'b111));
    check({tag, "_a_dout"},  32'({a, d_out}), 32'd0);
    check({tag, "_oe_rdy_rsp"}, 32'({d_oe, bus.cmd_ready, bus.rsp_valid}), 32'd0);
    check({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rsp_cnt, low_cnt, first_low, rsp_k;
    vec_t v;
    logic [7:0] exp_seq [3];

    vecs[0] = '{1'b1, REG_DATA0,   8'h5A, 8'h00, 8'h00};
    vecs[1] = '{1'b0, REG_ISR,     8'h00, 8'hC3, 8'hC3};
    vecs[2] = '{1'b1, REG_CTRL,    8'h11, 8'h00, 8'hC3};
    vecs[3] = '{1'b0, REG_ADDRX_L, 8'h00, 8'h3C, 8'h3C};
    vecs[4] = '{1'b1, 5'h1F,       8'hFF, 8'h00, 8'h3C};
    for (int i = 0; i < 32; i++) pad_mem[i] = 8'h00;

    reset = 1'b1;
    irq_n = 1'b1;
    bus.cmd_valid = 1'b0;  bus.cmd_write = 1'b0;  bus.cmd_addr = '0;  bus.cmd_wdata = '0;
    bus2.cmd_valid = 1'b0; bus2.cmd_write = 1'b0; bus2.cmd_addr = '0; bus2.cmd_wdata = '0;

    // Reset state, and cmd_ready rising on the first edge after release.
    #12;
    check_reset_values("reset");
    check("reset_irq", 32'(irq), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    // Single commands, default timing.
    for (int i = 0; i < 5; i++) run_cmd($sformatf("vec%0d", i), vecs[i]);

    // cmd_valid held for three reads: accepts every 5 cycles, 1-cycle cs_n gap.
    pad_mem[1] = 8'h11; pad_mem[2] = 8'h22; pad_mem[3] = 8'h33;
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
    @(negedge clk);
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 5'd1;
    bus.cmd_valid = 1'b1;
    check("b2b_ready_start", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("b2b_cs_k%0d", k), 32'(cs_n), 32'((k % 5) == 0 || k == 16));
      check($sformatf("b2b_rsp_k%0d", k), 32'(bus.rsp_valid), 32'((k % 5) == 0 && k <= 15));
      if ((k % 5) == 0 && k <= 15)
        check($sformatf("b2b_rdata_%0d", k / 5), 32'(bus.rsp_rdata), 32'(exp_seq[k / 5 - 1]));
      if (k == 5)  bus.cmd_addr = 5'd2;
      if (k == 10) bus.cmd_addr = 5'd3;
      if (k == 11) bus.cmd_valid = 1'b0;
    end

    // Reset during the strobe of a write.
    @(negedge clk);
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = REG_DATA1;
    bus.cmd_wdata = 8'hA5;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_wr_low", 32'(wr_n), 32'd0);
    #1 reset = 1'b1;
    #1 check_reset_values("midrst");
    @(negedge clk) reset = 1'b0;
    rsp_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_cnt++;
    end
    check("midrst_no_rsp", 32'(rsp_cnt), 32'd0);
    v = '{1'b0, REG_IEN, 8'h00, 8'h96, 8'h96};
    run_cmd("postrst_read", v);

    // Non-default timing on the second instance.
    @(negedge clk);
    bus2.cmd_write = 1'b1;
    bus2.cmd_addr  = REG_DATA0;
    bus2.cmd_wdata = 8'h77;
    bus2.cmd_valid = 1'b1;
    check("t342_ready", 32'(bus2.cmd_ready), 32'd1);
    @(posedge clk);
    #1 bus2.cmd_valid = 1'b0;
    low_cnt = 0; first_low = 0; rsp_k = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (!wr2_n) begin
        low_cnt++;
        if (first_low == 0) first_low = k;
      end
      if (bus2.rsp_valid && rsp_k == 0) rsp_k = k;
    end
    check("t342_wr_low_cycles", 32'(low_cnt), 32'd4);
    check("t342_wr_first_low", 32'(first_low), 32'd4);
    check("t342_rsp_latency", 32'(rsp_k), 32'd10);

    // Interrupt synchroniser: 2-edge latency in both directions.
    @(negedge clk);
    #1 irq_n = 1'b0;
    @(negedge clk);
    check("irq_fall_1clk", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_fall_2clk", 32'(irq), 32'd1);
    #1 irq_n = 1'b1;
    @(negedge clk);
    check("irq_rise_1clk", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_rise_2clk", 32'(irq), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
